pc_source_ctrl: RTL and testbench
=================================

PC_SOURCE_CTRL -- requirements
Module: pc_source_ctrl

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: clk (input, 1, rising-edge clock) and reset_n (input, 1, asynchronous active-low reset).
REQ-002 SHALL have port start (input, 1): one-cycle request to sequence the next instruction; sampled only in IDLE.
REQ-003 SHALL have port opcode (input, 6): instruction opcode, valid from the cycle after ir_write.
REQ-004 SHALL have port zero (input, 1): ALU zero flag, sampled in BRANCH.
REQ-005 SHALL have port overflow (input, 1): ALU overflow flag, sampled in EXEC.
REQ-006 SHALL have port exec_done (input, 1): datapath finished a non-control instruction, sampled in EXEC.
REQ-007 SHALL have port muxpcsource (output, 3): PC source select; 0=memory load data, 1=ALU result (PC+4), 2=ALUOut (branch target), 3=shifted jump target, 4=EPC.
REQ-008 SHALL have port pc_write (output, 1): PC load enable.
REQ-009 SHALL have port epc_write (output, 1): EPC load enable.
REQ-010 SHALL have port ir_write (output, 1): instruction register load enable.
REQ-011 SHALL have port mem_read (output, 1): memory read request.
REQ-012 SHALL have port exc_addr_sel (output, 2): exception vector select; 0=none, 1=invalid opcode, 2=overflow.
REQ-013 SHALL have port busy (output, 1): high in every state except IDLE.
REQ-014 SHALL have port done (output, 1): one-cycle pulse at instruction completion.

Function
REQ-015 SHALL implement a Moore FSM with states IDLE, FETCH, MEMWAIT, IRLOAD, DECODE, BRANCH, JUMP, RTE, EXEC, EXC_SAVE, EXC_READ, EXC_LOAD and DONE; every output is a function of state (BRANCH also uses opcode and zero).
REQ-016 SHALL drive every output not listed for a state to 0, including muxpcsource=0.
REQ-017 IDLE: on start=1, go to FETCH; otherwise stay.
REQ-018 FETCH: mem_read=1, muxpcsource=1, pc_write=1 for 1 cycle; then go to MEMWAIT.
REQ-019 MEMWAIT: mem_read=1 for exactly 2 cycles, counted by a 2-bit counter cleared on entry; then go to IRLOAD.
REQ-020 IRLOAD: ir_write=1 for 1 cycle; then go to DECODE.
REQ-021 DECODE: 1 cycle, decodes opcode.
- 0x04 (BEQ) or 0x05 (BNE) -> BRANCH.
- 0x02 (J) -> JUMP.
- 0x10 (RTE) -> RTE.
- 0x00, 0x08, 0x23, 0x2B -> EXEC.
- Any other value -> EXC_SAVE with cause 1.
REQ-022 BRANCH: muxpcsource=2; pc_write = zero for BEQ, !zero for BNE; then go to DONE.
REQ-023 JUMP: muxpcsource=3, pc_write=1; then go to DONE.
REQ-024 RTE: muxpcsource=4, pc_write=1; then go to DONE.
REQ-025 EXEC: hold with no outputs asserted until an exit condition.
- overflow=1 -> EXC_SAVE with cause 2.
- exec_done=1 -> DONE.
- Both high in the same cycle: overflow wins.
- No timeout.
REQ-026 Cause SHALL be held in a 2-bit register and SHALL be cleared in IDLE.
REQ-027 EXC_SAVE: epc_write=1 and exc_addr_sel=cause for 1 cycle; then go to EXC_READ.
REQ-028 EXC_READ: mem_read=1 and exc_addr_sel=cause for exactly 3 cycles (counter); then go to EXC_LOAD.
REQ-029 EXC_LOAD: muxpcsource=0, pc_write=1, exc_addr_sel=cause for 1 cycle; then go to DONE.
REQ-030 DONE: done=1 for 1 cycle; then go to IDLE unconditionally. start in DONE is ignored.
REQ-031 start asserted in any non-IDLE state SHALL be ignored and SHALL NOT be queued.
REQ-032 Fixed latencies, start to done pulse: BRANCH/JUMP/RTE = 7 cycles; invalid-opcode exception = 11 cycles; EXEC = 6 + number of EXEC cycles.
REQ-033 pc_write and epc_write SHALL never be high in the same cycle.

Reset
REQ-034 Asserting reset_n=0 SHALL immediately force IDLE, clear the counters and the cause register, and drive all outputs to 0 (muxpcsource=0, busy=0, done=0), irrespective of clk.
REQ-035 Reset asserted mid-sequence SHALL abort the sequence with no further pc_write, epc_write or ir_write; the first start after reset release begins a fresh FETCH.

Verification
REQ-036 JUMP: reset, start, opcode=0x02 -> FETCH pc_write with muxpcsource=1 at cycle 1; at cycle 6 pc_write=1 with muxpcsource=3; done at cycle 7; busy low at cycle 8.
REQ-037 BEQ: opcode=0x04 run twice, once with zero=1 and once with zero=0 -> BRANCH cycle shows muxpcsource=2 with pc_write=1 and 0 respectively.
REQ-038 Invalid opcode: opcode=0x3F -> epc_write=1 with exc_addr_sel=1; 3 cycles of mem_read; then pc_write=1 with muxpcsource=0; done at cycle 11.
REQ-039 EXEC: opcode=0x00, overflow=1 and exec_done=1 raised in the same EXEC cycle -> EXC_SAVE with exc_addr_sel=2 and no done pulse until after EXC_LOAD.
REQ-040 Reset in EXC_READ: reset_n pulled low mid-read -> all outputs 0 without a clock edge; a start after release shows FETCH outputs on the next cycle.
REQ-041 RTE with a stray start: opcode=0x10 with start held high throughout -> muxpcsource=4 with pc_write=1, one done pulse, and a new FETCH only after passing through IDLE.

Source files
------------

// File: rtl/pc_source_ctrl_if.sv
// Handshake and control bundle between the PC sequencing FSM and the datapath.
// The datapath side is the master; the controller is the slave.
interface pc_source_ctrl_if;
    logic       start;
    logic [5:0] opcode;
    logic       zero;
    logic       overflow;
    logic       exec_done;
    logic [2:0] muxpcsource;
    logic       pc_write;
    logic       epc_write;
    logic       ir_write;
    logic       mem_read;
    logic [1:0] exc_addr_sel;
    logic       busy;
    logic       done;

    modport master (
        output start, opcode, zero, overflow, exec_done,
        input  muxpcsource, pc_write, epc_write, ir_write, mem_read,
               exc_addr_sel, busy, done
    );

    modport slave (
        input  start, opcode, zero, overflow, exec_done,
        output muxpcsource, pc_write, epc_write, ir_write, mem_read,
               exc_addr_sel, busy, done
    );
endinterface

// File: rtl/pc_source_ctrl.sv
// Moore FSM that sequences fetch, decode, branch/jump/RTE, execution and
// exception entry, selecting the PC source and the PC/EPC/IR load enables.
module pc_source_ctrl (
    input  logic             clk,
    input  logic             reset_n,
    pc_source_ctrl_if.slave  bus
);
    typedef enum logic [3:0] {
        IDLE, FETCH, MEMWAIT, IRLOAD, DECODE, BRANCH, JUMP, RTE,
        EXEC, EXC_SAVE, EXC_READ, EXC_LOAD, DONE
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_RTE   = 6'h10;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [1:0] CAUSE_OPCODE   = 2'd1;
    localparam logic [1:0] CAUSE_OVERFLOW = 2'd2;

    state_t     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic [1:0] cause_q, cause_d;

    logic [2:0] muxpcsource;
    logic       pc_write, epc_write, ir_write, mem_read, busy, done;
    logic [1:0] exc_addr_sel;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            cause_q <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cause_q <= cause_d;
        end
    end

    // The shared counter is cleared on the way into each multi-cycle read state.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        cause_d      = cause_q;
        muxpcsource  = 3'd0;
        pc_write     = 1'b0;
        epc_write    = 1'b0;
        ir_write     = 1'b0;
        mem_read     = 1'b0;
        exc_addr_sel = 2'd0;
        busy         = (state_q != IDLE);
        done         = 1'b0;

        case (state_q)
            IDLE: begin
                cause_d = 2'd0;
                cnt_d   = 2'd0;
                if (bus.start) state_d = FETCH;
            end
            FETCH: begin
                mem_read    = 1'b1;
                muxpcsource = 3'd1;
                pc_write    = 1'b1;
                cnt_d       = 2'd0;
                state_d     = MEMWAIT;
            end
            MEMWAIT: begin
                mem_read = 1'b1;
                if (cnt_q == 2'd1) state_d = IRLOAD;
                else               cnt_d   = cnt_q + 2'd1;
            end
            IRLOAD: begin
                ir_write = 1'b1;
                state_d  = DECODE;
            end
            DECODE: begin
                case (bus.opcode)
                    OP_BEQ, OP_BNE:                    state_d = BRANCH;
                    OP_J:                              state_d = JUMP;
                    OP_RTE:                            state_d = RTE;
                    OP_RTYPE, OP_ADDI, OP_LW, OP_SW:   state_d = EXEC;
                    default: begin
                        cause_d = CAUSE_OPCODE;
                        state_d = EXC_SAVE;
                    end
                endcase
            end
            BRANCH: begin
                muxpcsource = 3'd2;
                pc_write    = (bus.opcode == OP_BEQ) ? bus.zero : !bus.zero;
                state_d     = DONE;
            end
            JUMP: begin
                muxpcsource = 3'd3;
                pc_write    = 1'b1;
                state_d     = DONE;
            end
            RTE: begin
                muxpcsource = 3'd4;
                pc_write    = 1'b1;
                state_d     = DONE;
            end
            EXEC: begin
                if (bus.overflow) begin
                    cause_d = CAUSE_OVERFLOW;
                    state_d = EXC_SAVE;
                end else if (bus.exec_done) begin
                    state_d = DONE;
                end
            end
            EXC_SAVE: begin
                epc_write    = 1'b1;
                exc_addr_sel = cause_q;
                cnt_d        = 2'd0;
                state_d      = EXC_READ;
            end
            EXC_READ: begin
                mem_read     = 1'b1;
                exc_addr_sel = cause_q;
                if (cnt_q == 2'd2) state_d = EXC_LOAD;
                else               cnt_d   = cnt_q + 2'd1;
            end
            EXC_LOAD: begin
                pc_write     = 1'b1;
                exc_addr_sel = cause_q;
                state_d      = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.muxpcsource  = muxpcsource;
    assign bus.pc_write     = pc_write;
    assign bus.epc_write    = epc_write;
    assign bus.ir_write     = ir_write;
    assign bus.mem_read     = mem_read;
    assign bus.exc_addr_sel = exc_addr_sel;
    assign bus.busy         = busy;
    assign bus.done         = done;
endmodule

// File: tb/tb_pc_source_ctrl.sv
// Scoreboard bench for pc_source_ctrl: expected per-cycle output vectors are
// queued when a sequence is launched and popped one per clock at the falling edge.
module tb_pc_source_ctrl;
    logic clk = 1'b0;
    logic reset_n;
    int   compareCount  = 0;
    int   mismatchCount = 0;
    logic [10:0] expQ[$];

    pc_source_ctrl_if bus();

    pc_source_ctrl dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Vector layout: {muxpcsource[2:0], pc_write, epc_write, ir_write, mem_read, exc_addr_sel[1:0], busy, done}
    localparam logic [10:0] V_IDLE    = 11'b000_0000_00_00;
    localparam logic [10:0] V_FETCH   = 11'b001_1001_00_10;
    localparam logic [10:0] V_MEMWAIT = 11'b000_0001_00_10;
    localparam logic [10:0] V_IRLOAD  = 11'b000_0010_00_10;
    localparam logic [10:0] V_DECODE  = 11'b000_0000_00_10;
    localparam logic [10:0] V_BR_TAKE = 11'b010_1000_00_10;
    localparam logic [10:0] V_BR_NOT  = 11'b010_0000_00_10;
    localparam logic [10:0] V_JUMP    = 11'b011_1000_00_10;
    localparam logic [10:0] V_RTE     = 11'b100_1000_00_10;
    localparam logic [10:0] V_EXEC    = 11'b000_0000_00_10;
    localparam logic [10:0] V_DONE    = 11'b000_0000_00_11;
    localparam logic [10:0] V_SAVE1   = 11'b000_0100_01_10;
    localparam logic [10:0] V_READ1   = 11'b000_0001_01_10;
    localparam logic [10:0] V_LOAD1   = 11'b000_1000_01_10;
    localparam logic [10:0] V_SAVE2   = 11'b000_0100_10_10;
    localparam logic [10:0] V_READ2   = 11'b000_0001_10_10;
    localparam logic [10:0] V_LOAD2   = 11'b000_1000_10_10;

    function automatic logic [10:0] observed();
        return {bus.muxpcsource, bus.pc_write, bus.epc_write, bus.ir_write,
                bus.mem_read, bus.exc_addr_sel, bus.busy, bus.done};
    endfunction

    task automatic checkOutput(input string tag, input logic [10:0] obs, input logic [10:0] exp);
        compareCount++;
        if (obs !== exp) begin
            mismatchCount++;
            $display("[TB] FAIL %s: observed %b, expected %b (mux|pw ew iw mr|exc|busy done)",
                     tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic st, input logic [5:0] op, input logic z,
                                 input logic ov, input logic ed);
        bus.start     = st;
        bus.opcode    = op;
        bus.zero      = z;
        bus.overflow  = ov;
        bus.exec_done = ed;
    endtask

    task automatic pushFront();
        expQ.push_back(V_FETCH);
        expQ.push_back(V_MEMWAIT);
        expQ.push_back(V_MEMWAIT);
        expQ.push_back(V_IRLOAD);
        expQ.push_back(V_DECODE);
    endtask

    // One clock, then compare against the head of the scoreboard at the falling edge.
    task automatic stepAndCheck(input string tag);
        @(posedge clk);
        @(negedge clk);
        if (expQ.size() == 0)
            checkOutput({tag, " (scoreboard empty)"}, observed(), 11'bx);
        else
            checkOutput(tag, observed(), expQ.pop_front());
    endtask

    task automatic runSteps(input int n, input string tag, input int firstCycle);
        for (int i = 0; i < n; i++)
            stepAndCheck($sformatf("%s c%0d", tag, firstCycle + i));
    endtask

    // Launch a three-step control instruction (branch/jump/RTE) and track it back to IDLE.
    task automatic runControl(input logic [5:0] op, input logic z, input logic [10:0] mid,
                              input string tag);
        applyStimulus(1'b1, op, z, 1'b0, 1'b0);
        pushFront();
        expQ.push_back(mid);
        expQ.push_back(V_DONE);
        expQ.push_back(V_IDLE);
        stepAndCheck({tag, " c1"});
        bus.start = 1'b0;
        runSteps(7, tag, 2);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset_n = 1'b0;
        applyStimulus(1'b0, 6'h00, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("reset state", observed(), V_IDLE);
        reset_n = 1'b1;

        runControl(6'h02, 1'b0, V_JUMP,    "jump");
        runControl(6'h04, 1'b1, V_BR_TAKE, "beq zero=1");
        runControl(6'h04, 1'b0, V_BR_NOT,  "beq zero=0");
        runControl(6'h05, 1'b0, V_BR_TAKE, "bne zero=0");
        runControl(6'h05, 1'b1, V_BR_NOT,  "bne zero=1");

        // Invalid opcode: exception entry, done at cycle 11.
        applyStimulus(1'b1, 6'h3F, 1'b0, 1'b0, 1'b0);
        pushFront();
        expQ.push_back(V_SAVE1);
        repeat (3) expQ.push_back(V_READ1);
        expQ.push_back(V_LOAD1);
        expQ.push_back(V_DONE);
        expQ.push_back(V_IDLE);
        stepAndCheck("badop c1");
        bus.start = 1'b0;
        runSteps(11, "badop", 2);

        // Normal EXEC with one EXEC cycle: done at cycle 7.
        applyStimulus(1'b1, 6'h2B, 1'b0, 1'b0, 1'b0);
        pushFront();
        expQ.push_back(V_EXEC);
        expQ.push_back(V_DONE);
        expQ.push_back(V_IDLE);
        stepAndCheck("exec c1");
        bus.start = 1'b0;
        runSteps(5, "exec", 2);
        bus.exec_done = 1'b1;
        stepAndCheck("exec c7");
        bus.exec_done = 1'b0;
        stepAndCheck("exec c8");

        // EXEC held three cycles, then overflow and exec_done together: overflow wins.
        applyStimulus(1'b1, 6'h00, 1'b0, 1'b0, 1'b0);
        pushFront();
        repeat (3) expQ.push_back(V_EXEC);
        stepAndCheck("ovf c1");
        bus.start = 1'b0;
        runSteps(7, "ovf", 2);
        bus.overflow  = 1'b1;
        bus.exec_done = 1'b1;
        expQ.push_back(V_SAVE2);
        repeat (3) expQ.push_back(V_READ2);
        expQ.push_back(V_LOAD2);
        expQ.push_back(V_DONE);
        expQ.push_back(V_IDLE);
        stepAndCheck("ovf c9");
        bus.overflow  = 1'b0;
        bus.exec_done = 1'b0;
        runSteps(6, "ovf", 10);

        // Reset between clock edges during EXC_READ.
        applyStimulus(1'b1, 6'h3F, 1'b0, 1'b0, 1'b0);
        pushFront();
        expQ.push_back(V_SAVE1);
        expQ.push_back(V_READ1);
        stepAndCheck("rstmid c1");
        bus.start = 1'b0;
        runSteps(6, "rstmid", 2);
        #2 reset_n = 1'b0;
        #1 checkOutput("async reset in EXC_READ", observed(), V_IDLE);
        @(negedge clk);
        checkOutput("held in reset", observed(), V_IDLE);
        reset_n = 1'b1;
        runControl(6'h02, 1'b0, V_JUMP, "after reset");

        // RTE with start held high throughout: the new FETCH follows an IDLE cycle.
        applyStimulus(1'b1, 6'h10, 1'b0, 1'b0, 1'b0);
        pushFront();
        expQ.push_back(V_RTE);
        expQ.push_back(V_DONE);
        expQ.push_back(V_IDLE);
        expQ.push_back(V_FETCH);
        runSteps(9, "rte stray", 1);
        bus.start = 1'b0;
        expQ.push_back(V_MEMWAIT);
        expQ.push_back(V_MEMWAIT);
        expQ.push_back(V_IRLOAD);
        expQ.push_back(V_DECODE);
        expQ.push_back(V_RTE);
        expQ.push_back(V_DONE);
        expQ.push_back(V_IDLE);
        runSteps(7, "rte second", 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end
endmodule
